// File: rtl/truth_table_capture.sv
// Exhaustive stimulus driver and response capture for a small combinational DUT.
// Sweeps every input vector, samples z_in after a settle window, and compares the result to EXPECTED.
module truth_table_capture #(
  parameter int                  N_IN       = 3,
  parameter int                  SETTLE_CYC = 4,
  parameter logic [2**N_IN-1:0]  EXPECTED   = 8'hE8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                z_in,
  output logic [N_IN-1:0]     abc_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2**N_IN-1:0]  truth_table,
  output logic [N_IN:0]       mismatch_cnt,
  output logic [N_IN-1:0]     first_fail_idx,
  output logic                fail_seen
);

  localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [TW-1:0]   LAST_TICK = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]   TICK_ONE  = TW'(1);
  localparam logic [N_IN-1:0] LAST_VEC  = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE   = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   timer_r;
  logic            miss_s;

  assign miss_s = (z_in != EXPECTED[abc_out]);

  // Sweep sequencer: arms on start, holds each vector SETTLE_CYC cycles, samples on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      timer_r        <= '0;
      abc_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      truth_table    <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      fail_seen      <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r        <= RUN;
            timer_r        <= '0;
            abc_out        <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            truth_table    <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            fail_seen      <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          if (abort) begin
            // Partial capture results stay visible until the next start.
            state_r <= IDLE;
            busy    <= 1'b0;
            abc_out <= '0;
            timer_r <= '0;
          end else if (timer_r != LAST_TICK) begin
            timer_r <= timer_r + TICK_ONE;
          end else begin
            truth_table[abc_out] <= z_in;
            if (miss_s) begin
              mismatch_cnt <= mismatch_cnt + CNT_ONE;
              if (!fail_seen) begin
                first_fail_idx <= abc_out;
                fail_seen      <= 1'b1;
              end else begin
                first_fail_idx <= first_fail_idx;
              end
            end else begin
              mismatch_cnt <= mismatch_cnt;
            end
            if (abc_out == LAST_VEC) begin
              // The final sample's miss is folded in here since mismatch_cnt updates on this same edge.
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (mismatch_cnt == '0) && !miss_s;
            end else begin
              abc_out <= abc_out + VEC_ONE;
              timer_r <= '0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

endmodule
